// File: rtl/fifo_stat.sv
// fifo_stat: register-array FIFO with occupancy count, almost thresholds,
// sticky overflow/underflow flags and synchronous flush.
module fifo_stat #(
   parameter int B  = 8,
   parameter int W  = 4,
   parameter int AE = 1,
   parameter int AF = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         rd,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow
);
   localparam int D = 1 << W;
   localparam logic [W:0] D_C  = (W+1)'(D);
   localparam logic [W:0] AE_C = (W+1)'(AE);
   localparam logic [W:0] AF_C = (W+1)'(AF);

   logic [B-1:0] mem [D];
   logic [W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
   logic [W:0]   count_q, count_d;
   logic         empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
   logic         ovf_d, unf_d, wr_acc, rd_acc;

   // a write into a full FIFO is still accepted when a read frees the slot
   always_comb begin
      wr_acc  = wr & (~full_q | rd) & ~clr;
      rd_acc  = rd & ~empty_q & ~clr;
      w_ptr_d = clr ? '0 : wr_acc ? w_ptr_q + 1'b1 : w_ptr_q;
      r_ptr_d = clr ? '0 : rd_acc ? r_ptr_q + 1'b1 : r_ptr_q;
      count_d = clr ? '0 : (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
      ovf_d   = ~clr & (ovf_q | (wr & ~wr_acc));
      unf_d   = ~clr & (unf_q | (rd & empty_q));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         empty_q <= count_d == '0;
         full_q  <= count_d == D_C;
         ae_q    <= count_d <= AE_C;
         af_q    <= count_d >= AF_C;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk)
      if (wr_acc) mem[w_ptr_q] <= w_data;

   assign r_data       = mem[r_ptr_q];
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
endmodule

// File: tb/tb_fifo_stat.sv
// tb_fifo_stat: directed stimulus with a data scoreboard; a negedge monitor
// checks every accepted pop against the queue of expected words.
module tb_fifo_stat;
   logic       clk = 1'b0, reset = 1'b0, clr = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [7:0] w_data = '0, r_data;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [4:0] count;
   int         total = 0, bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] e;

   fifo_stat #(.B(8), .W(4), .AE(1), .AF(14)) dut (
      .clk(clk), .reset(reset), .clr(clr), .rd(rd), .wr(wr), .w_data(w_data),
      .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
      .almost_full(almost_full), .count(count), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (reset && !clr && rd && !empty) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop: r_data=%h but no word expected", r_data);
         end else begin
            e = exp_q.pop_front();
            if (r_data !== e) begin
               bad++;
               $display("FAIL pop: r_data=%h expected=%h", r_data, e);
            end
         end
      end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
      wr = w; rd = r; w_data = d; clr = c;
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      exp_q.push_back(d);
      step(1'b1, 1'b0, d, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      // 1: reset state and first-word fall-through
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_flags", {overflow, underflow}, 0);
      push(8'hA5);
      chk("fwft_data", r_data, 8'hA5);
      chk("fwft_count", count, 1);
      chk("fwft_empty", empty, 0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("fwft_drain", count, 0);
      // 2: fill to full, overflow, drain in order
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk("fill_af", almost_full, int'(i + 1 >= 14));
      end
      chk("fill_count", count, 16);
      chk("fill_full", full, 1);
      step(1'b1, 1'b0, 8'hFF, 1'b0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_count", count, 16);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0);
         chk("drain_ae", almost_empty, int'(15 - i <= 1));
      end
      chk("drain_empty", empty, 1);
      // 3: underflow, then simultaneous read/write on empty
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("unf_flag", underflow, 1);
      chk("unf_count", count, 0);
      exp_q.push_back(8'h3C);
      step(1'b1, 1'b1, 8'h3C, 1'b0);
      chk("rw_empty_count", count, 1);
      chk("rw_empty_data", r_data, 8'h3C);
      chk("rw_empty_empty", empty, 0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("clr_flags", {overflow, underflow}, 0);
      // 4: simultaneous read/write while full
      for (int i = 0; i < 16; i++) push(8'(i));
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h77);
         step(1'b1, 1'b1, 8'h77, 1'b0);
      end
      chk("rw_full_count", count, 16);
      chk("rw_full_full", full, 1);
      chk("rw_full_ovf", overflow, 0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("rw_full_drain", empty, 1);
      // 5: wrap-around with alternating write/read
      for (int i = 0; i < 20; i++) begin
         push(8'h40 + 8'(i));
         chk("wrap_cnt1", count, 1);
         step(1'b0, 1'b1, 8'h00, 1'b0);
         chk("wrap_cnt0", count, 0);
      end
      // 6: flush with a write pending, then asynchronous reset mid-operation
      for (int i = 0; i < 16; i++) begin
         if (i < 7) exp_q.push_back(8'(i));
         step(1'b1, 1'b0, 8'(i), 1'b0);
      end
      step(1'b1, 1'b0, 8'hFF, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("pre_clr_count", count, 9);
      chk("pre_clr_ovf", overflow, 1);
      step(1'b1, 1'b0, 8'hEE, 1'b1);
      chk("clr_count", count, 0);
      chk("clr_empty", empty, 1);
      chk("clr_ovf", overflow, 0);
      push(8'h11);
      chk("clr_drop", r_data, 8'h11);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h90 + 8'(i), 1'b0);
      chk("refill_count", count, 5);
      #2 reset = 1'b0;
      #1;
      chk("async_count", count, 0);
      chk("async_empty", empty, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      push(8'h5A);
      chk("post_rst_data", r_data, 8'h5A);
      chk("post_rst_count", count, 1);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
